multicycle_controller: RTL and testbench

- Moore-style sequencer for the multicycle RISC-V core: one instruction over 3–5 cycles, sharing a single ALU and a unified instruction/data memory port.
- Decodes the instruction-register fields and drives every datapath select and write enable per cycle.
- Replaces the single-cycle control path; sits between the instruction register and the datapath muxes.

---
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore-style control sequencer for a multicycle RISC-V core. One
//   instruction takes 3-5 cycles through a shared ALU and a unified
//   instruction/data memory port. Decodes the instruction-register fields
//   and drives every datapath select and write enable each cycle.
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RESET        synchronous, active-high; loads FETCH and masks write enables
//   OP/FUNCT_3/FUNCT_7_5  instruction-register fields
//   ZERO         ALU zero flag, consulted only in BEQ
//   MEM_READY    memory handshake, only honoured with MEM_READY_EN
//   PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, RESULT_SRC, ALU_SRC_A,
//   ALU_SRC_B, IMM_SRC, ALU_CONTROL, REG_WRITE  datapath controls
//   ILLEGAL_OP   one-cycle pulse in DECODE for an unsupported opcode
//   STATE        current state encoding (debug)
//
// Configuration
//   MEM_READY_EN  when defined, FETCH, MEMREAD and MEMWRITE stall while
//                 MEM_READY=0; otherwise every memory state lasts one cycle.
module multicycle_controller (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OP,
  input  logic [2:0] FUNCT_3,
  input  logic       FUNCT_7_5,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       PC_WRITE,
  output logic       ADR_SRC,
  output logic       MEM_WRITE,
  output logic       IR_WRITE,
  output logic [1:0] RESULT_SRC,
  output logic [1:0] ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [1:0] IMM_SRC,
  output logic [2:0] ALU_CONTROL,
  output logic       REG_WRITE,
  output logic       ILLEGAL_OP,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t state_q, state_d;
  state_t cur_state;
  logic   mem_ok;
  logic   pc_update, branch;
  logic   pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

  // Register-register ops use bit 30 to select sub; immediate ops have OP[5]=0
  // so "addi" with bit 30 set still adds.
  function automatic logic [2:0] funct_alu(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic       f75);
    case (f3)
      3'b000:  funct_alu = (op[5] & f75) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  endfunction

`ifdef MEM_READY_EN
  assign mem_ok = MEM_READY;
`else
  // Handshake ignored: memory states always complete in one cycle.
  assign mem_ok = MEM_READY | 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    // During reset the outputs decode as FETCH so the datapath sees a sane
    // select pattern; write enables are masked separately below.
    cur_state     = RESET ? S_FETCH : state_q;
    state_d       = S_FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ADR_SRC       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    RESULT_SRC    = 2'b00;
    ALU_SRC_A     = 2'b00;
    ALU_SRC_B     = 2'b00;
    ALU_CONTROL   = 3'b000;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ir_write_raw = mem_ok;
        pc_update    = mem_ok;
        ALU_SRC_B    = 2'b10;
        RESULT_SRC   = 2'b10;
        state_d      = mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALU_SRC_A = 2'b01;
        ALU_SRC_B = 2'b01;
        case (OP)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALU_SRC_A = 2'b10;
        ALU_SRC_B = 2'b01;
        state_d   = (OP == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ADR_SRC = 1'b1;
        state_d = mem_ok ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        RESULT_SRC    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        ADR_SRC       = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = mem_ok ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALU_SRC_A   = 2'b10;
        ALU_CONTROL = funct_alu(OP, FUNCT_3, FUNCT_7_5);
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALU_SRC_A   = 2'b10;
        ALU_SRC_B   = 2'b01;
        ALU_CONTROL = funct_alu(OP, FUNCT_3, FUNCT_7_5);
        state_d     = S_ALUWB;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        ALU_SRC_A   = 2'b10;
        ALU_CONTROL = 3'b001;
        branch      = 1'b1;
      end
      S_JAL: begin
        ALU_SRC_A = 2'b01;
        ALU_SRC_B = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    pc_write_raw = (branch & ZERO) | pc_update;
  end

  always_comb begin
    case (OP)
      OP_STORE: IMM_SRC = 2'b01;
      OP_BEQ:   IMM_SRC = 2'b10;
      OP_JAL:   IMM_SRC = 2'b11;
      default:  IMM_SRC = 2'b00;
    endcase
  end

  assign PC_WRITE   = pc_write_raw  & ~RESET;
  assign MEM_WRITE  = mem_write_raw & ~RESET;
  assign IR_WRITE   = ir_write_raw  & ~RESET;
  assign REG_WRITE  = reg_write_raw & ~RESET;
  assign ILLEGAL_OP = illegal_raw   & ~RESET;
  assign STATE      = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed scenarios followed by random
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [6:0] OP;
  logic [2:0] FUNCT_3;
  logic       FUNCT_7_5;
  logic       ZERO;
  logic       MEM_READY;
  logic       PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, REG_WRITE, ILLEGAL_OP;
  logic [1:0] RESULT_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC;
  logic [2:0] ALU_CONTROL;
  logic [3:0] STATE;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  multicycle_controller dut (
    .CLK(CLK), .RESET(RESET), .OP(OP), .FUNCT_3(FUNCT_3), .FUNCT_7_5(FUNCT_7_5),
    .ZERO(ZERO), .MEM_READY(MEM_READY), .PC_WRITE(PC_WRITE), .ADR_SRC(ADR_SRC),
    .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE), .RESULT_SRC(RESULT_SRC),
    .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .IMM_SRC(IMM_SRC),
    .ALU_CONTROL(ALU_CONTROL), .REG_WRITE(REG_WRITE), .ILLEGAL_OP(ILLEGAL_OP),
    .STATE(STATE)
  );

  // Instruction classes
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  // Expected control word per state:
  // {PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, RESULT_SRC, A, B, ALU, REG_WRITE}
  logic [13:0] ctl_tbl [0:10];

  function automatic logic [13:0] observed_ctl();
    return {PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, RESULT_SRC,
            ALU_SRC_A, ALU_SRC_B, ALU_CONTROL, REG_WRITE};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BEQ:   return 7'b1100011;
      K_JAL:   return 7'b1101111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    for (int k = 0; k < 6; k++) if (op == op_of(k)) return 1'b1;
    return 1'b0;
  endfunction

  // Arithmetic operation an R/I instruction asks for, as an ALU code.
  function automatic logic [2:0] model_alu(input int kind, input logic [2:0] f3, input logic f75);
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b000 && kind == K_R && f75) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [1:0] model_imm(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Runs one full instruction starting in FETCH. zero_force < 0 randomizes ZERO.
  task automatic run_instr(input int kind, input logic [2:0] f3, input logic f75,
                           input logic [6:0] ill_op, input int zero_force);
    int q[$];
    logic [13:0] exp;
    case (kind)
      K_LW:    q = '{0, 1, 2, 3, 4};
      K_SW:    q = '{0, 1, 2, 5};
      K_R:     q = '{0, 1, 6, 8};
      K_I:     q = '{0, 1, 7, 8};
      K_BEQ:   q = '{0, 1, 9};
      K_JAL:   q = '{0, 1, 10, 8};
      default: q = '{0, 1};
    endcase
    OP        = (kind == K_ILL) ? ill_op : op_of(kind);
    FUNCT_3   = f3;
    FUNCT_7_5 = f75;
    foreach (q[i]) begin
      ZERO = (zero_force < 0) ? 1'($urandom) : 1'(zero_force);
`ifdef MEM_READY_EN
      MEM_READY = 1'b1;
`else
      MEM_READY = 1'($urandom);
`endif
      #1;
      exp = ctl_tbl[q[i]];
      if (q[i] == 6 || q[i] == 7) exp[3:1] = model_alu(kind, f3, f75);
      if (q[i] == 9) exp[13] = ZERO;
      check($sformatf("state k%0d c%0d", kind, i), STATE, q[i]);
      check($sformatf("ctl k%0d s%0d", kind, q[i]), observed_ctl(), exp);
      check($sformatf("imm k%0d", kind), IMM_SRC, model_imm(OP));
      check($sformatf("illegal k%0d s%0d", kind, q[i]), ILLEGAL_OP,
            (q[i] == 1 && !is_legal(OP)));
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    logic [6:0] rop;
    int kind, pcw_cnt;
    ctl_tbl[0]  = {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};
    ctl_tbl[1]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0};
    ctl_tbl[2]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0};
    ctl_tbl[3]  = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    ctl_tbl[4]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1};
    ctl_tbl[5]  = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    ctl_tbl[6]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
    ctl_tbl[7]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0};
    ctl_tbl[8]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};
    ctl_tbl[9]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0};
    ctl_tbl[10] = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0};

    // Reset held for two cycles with an R-type opcode present
    RESET = 1'b1; OP = 7'b0110011; FUNCT_3 = 3'b000; FUNCT_7_5 = 1'b0;
    ZERO = 1'b1; MEM_READY = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("rst state", STATE, 4'd0);
      check("rst wen", {PC_WRITE, IR_WRITE, MEM_WRITE, REG_WRITE, ILLEGAL_OP}, 5'b0);
      check("rst alub", ALU_SRC_B, 2'b10);
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
    #1;
    check("post-rst fetch", {IR_WRITE, PC_WRITE, ALU_SRC_B}, 4'b1110);

    // Directed instructions
    run_instr(K_LW,  3'b010, 1'b0, 7'd0, -1);
    run_instr(K_R,   3'b000, 1'b1, 7'd0, -1);
    run_instr(K_R,   3'b111, 1'b0, 7'd0, -1);
    run_instr(K_I,   3'b000, 1'b1, 7'd0, -1);
    run_instr(K_BEQ, 3'b000, 1'b0, 7'd0, 1);
    run_instr(K_BEQ, 3'b000, 1'b0, 7'd0, 0);
    run_instr(K_JAL, 3'b000, 1'b0, 7'd0, -1);
    run_instr(K_ILL, 3'b000, 1'b0, 7'b1111111, -1);
    run_instr(K_SW,  3'b010, 1'b0, 7'd0, -1);

    // Reset in the middle of an R-type writeback aborts it
    OP = 7'b0110011; FUNCT_3 = 3'b110; FUNCT_7_5 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("pre-abort aluwb", STATE, 4'd8);
    RESET = 1'b1;
    #1;
    check("abort state", STATE, 4'd0);
    check("abort wen", {PC_WRITE, IR_WRITE, MEM_WRITE, REG_WRITE}, 4'b0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    check("abort resume", STATE, 4'd0);

`ifdef MEM_READY_EN
    // Store stalled in MEMWRITE for three cycles
    OP = 7'b0100011; MEM_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    MEM_READY = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) MEM_READY = 1'b1;
      #1;
      check($sformatf("sw stall state c%0d", c), STATE, 4'd5);
      check($sformatf("sw stall memw c%0d", c), MEM_WRITE, 1'b1);
      @(posedge CLK); #1;
    end
    check("sw stall exit", STATE, 4'd0);

    // Fetch stalled two cycles: exactly one PC increment
    pcw_cnt = 0;
    MEM_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) MEM_READY = 1'b1;
      #1;
      check($sformatf("fetch stall state c%0d", c), STATE, 4'd0);
      if (PC_WRITE) pcw_cnt++;
      @(posedge CLK); #1;
    end
    check("fetch stall pcw count", pcw_cnt, 1);
    check("fetch stall exit", STATE, 4'd1);
    repeat (3) @(posedge CLK);
    #1;
    check("fetch stall sw done", STATE, 4'd0);
`endif

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 6);
      do rop = 7'($urandom); while (is_legal(rop));
      run_instr(kind, 3'($urandom), 1'($urandom), rop, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
